// File: rtl/ucode_pkg.sv
// ucode_pkg: definitions shared by the microcode loader, the SAP-2 controller
// and the testbench. It holds the loader FSM states, the error codes, the
// frame/word geometry and the bit positions of control-word fields.
package ucode_pkg;

  localparam int          WORD_W = 35;
  localparam int          ADDR_W = 12;
  localparam logic [7:0]  SYNC   = 8'hA5;

  // Bytes per control word on the link, least-significant byte first.
  localparam int          WORD_BYTES = 5;

  // Error codes reported on err_code.
  localparam logic [1:0]  ERR_NONE = 2'd0;
  localparam logic [1:0]  ERR_ADDR = 2'd1;
  localparam logic [1:0]  ERR_WORD = 2'd2;
  localparam logic [1:0]  ERR_CHK  = 2'd3;

  // Outer control-word bit positions. The controller and the bench use the
  // same indices so that both agree on the layout.
  localparam int          CW_END = 34;
  localparam int          CW_RET = 0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ADDR_H = 3'd1,
    ST_ADDR_L = 3'd2,
    ST_COUNT  = 3'd3,
    ST_DATA   = 3'd4,
    ST_WRITE  = 3'd5,
    ST_CHECK  = 3'd6
  } ld_state_e;

endpackage

// File: rtl/ucode_word_asm.sv
// ucode_word_asm: assembles one control word from five link bytes.
//   clk, rst_n  : clock, synchronous active-low reset
//   clr         : restart at byte 0 (new frame)
//   byte_en     : a data byte is being accepted this cycle
//   byte_in     : the data byte
//   word        : assembled word, valid while word_ready is high
//   word_ready  : final byte accepted and its unused upper bits are zero
//   top_bad     : final byte accepted with nonzero unused upper bits
// word/word_ready/top_bad are combinational on the final byte so the loader
// can register the store write directly on the next edge.
module ucode_word_asm
  import ucode_pkg::*;
#(
  parameter int WORD_W_P = WORD_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                byte_en,
  input  logic [7:0]          byte_in,
  output logic [WORD_W_P-1:0] word,
  output logic                word_ready,
  output logic                top_bad
);

  // Number of payload bits carried by the final byte.
  localparam int TOP_W = WORD_W_P - 32;

  logic [2:0]  idx_q, idx_d;
  logic [31:0] lo_q, lo_d;
  logic        last_byte;
  logic        top_ok;

  assign last_byte = (idx_q == 3'(WORD_BYTES - 1));
  assign top_ok    = (byte_in[7:TOP_W] == '0);

  always_comb begin
    idx_d = idx_q;
    lo_d  = lo_q;
    if (clr) begin
      idx_d = '0;
    end else if (byte_en) begin
      if (last_byte) begin
        idx_d = '0;
      end else begin
        idx_d = idx_q + 3'd1;
        // Bytes arrive LSB first, so shift each new byte in from the top.
        lo_d  = {byte_in, lo_q[31:8]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q <= '0;
      lo_q  <= '0;
    end else begin
      idx_q <= idx_d;
      lo_q  <= lo_d;
    end
  end

  assign word       = {byte_in[TOP_W-1:0], lo_q};
  assign word_ready = byte_en & last_byte & top_ok;
  assign top_bad    = byte_en & last_byte & ~top_ok;

endmodule

// File: rtl/ucode_loader.sv
// ucode_loader: receives framed bytes from the host link and writes 35-bit
// microcode words into the control store. It holds the CPU in reset until a
// frame with a correct checksum has loaded.
//   clk, rst_n         : clock, synchronous active-low reset
//   in_data, in_valid  : stream byte and its valid flag
//   in_ready           : byte accepted when in_valid & in_ready
//   rom_we/addr/wdata  : registered control-store write port
//   cpu_hold           : keep the CPU in reset
//   busy               : a frame is in progress
//   done               : one-cycle pulse after a good frame
//   err, err_code      : sticky error, cleared by the next SYNC
//
// Frame: SYNC ADDR_H ADDR_L CNT {5 bytes}x(CNT+1) CHK
//
// state   | meaning
// --------+----------------------------------------------------
// IDLE    | discard bytes until SYNC
// ADDR_H  | start address [11:8]; upper nibble must be zero
// ADDR_L  | start address [7:0]
// COUNT   | number of words minus one
// DATA    | collect the 5 bytes of one word
// WRITE   | store strobe cycle; link stalled; advance address/count
// CHECK   | compare received CHK with the running XOR
module ucode_loader
  import ucode_pkg::*;
#(
  parameter int         WORD_W_P = WORD_W,
  parameter int         ADDR_W_P = ADDR_W,
  parameter logic [7:0] SYNC_P   = SYNC
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [7:0]          in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                rom_we,
  output logic [ADDR_W_P-1:0] rom_addr,
  output logic [WORD_W_P-1:0] rom_wdata,
  output logic                cpu_hold,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [1:0]          err_code
);

  ld_state_e             state_q, state_d;
  logic [ADDR_W_P-1:0]   addr_q, addr_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [7:0]            chk_q, chk_d;
  logic                  rom_we_q, rom_we_d;
  logic [ADDR_W_P-1:0]   rom_addr_q, rom_addr_d;
  logic [WORD_W_P-1:0]   rom_wdata_q, rom_wdata_d;
  logic                  cpu_hold_q, cpu_hold_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [1:0]            err_code_q, err_code_d;

  logic                  acc;
  logic                  sync_acc;
  logic                  asm_en;
  logic [WORD_W_P-1:0]   asm_word;
  logic                  asm_ready;
  logic                  asm_bad;

  assign in_ready = (state_q != ST_WRITE);
  assign acc      = in_valid & in_ready;
  assign sync_acc = acc & (state_q == ST_IDLE) & (in_data == SYNC_P);
  assign asm_en   = acc & (state_q == ST_DATA);

  ucode_word_asm #(
    .WORD_W_P (WORD_W_P)
  ) u_word_asm (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (sync_acc),
    .byte_en    (asm_en),
    .byte_in    (in_data),
    .word       (asm_word),
    .word_ready (asm_ready),
    .top_bad    (asm_bad)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    chk_d       = chk_q;
    rom_we_d    = 1'b0;
    rom_addr_d  = rom_addr_q;
    rom_wdata_d = rom_wdata_q;
    cpu_hold_d  = cpu_hold_q;
    done_d      = 1'b0;
    err_d       = err_q;
    err_code_d  = err_code_q;

    unique case (state_q)
      ST_IDLE: begin
        if (sync_acc) begin
          err_d      = 1'b0;
          err_code_d = ERR_NONE;
          cpu_hold_d = 1'b1;
          chk_d      = '0;
          state_d    = ST_ADDR_H;
        end
      end

      ST_ADDR_H: begin
        if (acc) begin
          chk_d = chk_q ^ in_data;
          if (in_data[7:4] != 4'h0) begin
            err_d      = 1'b1;
            err_code_d = ERR_ADDR;
            state_d    = ST_IDLE;
          end else begin
            addr_d  = {in_data[ADDR_W_P-9:0], addr_q[7:0]};
            state_d = ST_ADDR_L;
          end
        end
      end

      ST_ADDR_L: begin
        if (acc) begin
          chk_d       = chk_q ^ in_data;
          addr_d[7:0] = in_data;
          state_d     = ST_COUNT;
        end
      end

      ST_COUNT: begin
        if (acc) begin
          chk_d   = chk_q ^ in_data;
          cnt_d   = in_data;
          state_d = ST_DATA;
        end
      end

      ST_DATA: begin
        if (acc) begin
          chk_d = chk_q ^ in_data;
          if (asm_bad) begin
            err_d      = 1'b1;
            err_code_d = ERR_WORD;
            state_d    = ST_IDLE;
          end else if (asm_ready) begin
            rom_we_d    = 1'b1;
            rom_addr_d  = addr_q;
            rom_wdata_d = asm_word;
            state_d     = ST_WRITE;
          end
        end
      end

      ST_WRITE: begin
        // Address wraps naturally at the store size.
        addr_d = addr_q + ADDR_W_P'(1);
        if (cnt_q == 8'd0) begin
          state_d = ST_CHECK;
        end else begin
          cnt_d   = cnt_q - 8'd1;
          state_d = ST_DATA;
        end
      end

      ST_CHECK: begin
        if (acc) begin
          if (in_data == chk_q) begin
            done_d     = 1'b1;
            cpu_hold_d = 1'b0;
          end else begin
            err_d      = 1'b1;
            err_code_d = ERR_CHK;
          end
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      cnt_q       <= '0;
      chk_q       <= '0;
      rom_we_q    <= 1'b0;
      rom_addr_q  <= '0;
      rom_wdata_q <= '0;
      cpu_hold_q  <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      chk_q       <= chk_d;
      rom_we_q    <= rom_we_d;
      rom_addr_q  <= rom_addr_d;
      rom_wdata_q <= rom_wdata_d;
      cpu_hold_q  <= cpu_hold_d;
      done_q      <= done_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
    end
  end

  assign rom_we    = rom_we_q;
  assign rom_addr  = rom_addr_q;
  assign rom_wdata = rom_wdata_q;
  assign cpu_hold  = cpu_hold_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign err       = err_q;
  assign err_code  = err_code_q;

endmodule

// File: tb/tb_ucode_loader.sv
// Directed testbench for ucode_loader. Frames are hand-built byte lists
// with hand-computed checksums and expected store writes.
module tb_ucode_loader;
  import ucode_pkg::*;

  logic              clk;
  logic              rst_n;
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              rom_we;
  logic [ADDR_W-1:0] rom_addr;
  logic [WORD_W-1:0] rom_wdata;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              err;
  logic [1:0]        err_code;

  ucode_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .rom_we    (rom_we),
    .rom_addr  (rom_addr),
    .rom_wdata (rom_wdata),
    .cpu_hold  (cpu_hold),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .err_code  (err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Store-write monitor.
  int                cyc = 0;
  logic [ADDR_W-1:0] wa_q[$];
  logic [WORD_W-1:0] wd_q[$];
  int                wc_q[$];
  int                done_cnt = 0;
  int                rdy_in_write = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rom_we) begin
      wa_q.push_back(rom_addr);
      wd_q.push_back(rom_wdata);
      wc_q.push_back(cyc);
      if (in_ready) rdy_in_write++;
    end
    if (done) done_cnt++;
  end

  logic [7:0] frm[$];

  task automatic clear_log();
    wa_q.delete();
    wd_q.delete();
    wc_q.delete();
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge; returns at the negedge after the byte was taken.
  task automatic send_byte(input logic [7:0] b);
    int k;
    k = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) check("in_ready_timeout", 64'd0, 64'd1);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_frame(input int gap_max);
    for (int i = 0; i < frm.size(); i++) begin
      send_byte(frm[i]);
      if (gap_max > 0 && i < frm.size() - 1) idle($urandom_range(0, gap_max));
    end
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_cpu_hold"}, 64'(cpu_hold), 64'd1);
    check({pfx, "_rom_we"},   64'(rom_we),   64'd0);
    check({pfx, "_rom_addr"}, 64'(rom_addr), 64'd0);
    check({pfx, "_rom_wdata"},64'(rom_wdata),64'd0);
    check({pfx, "_busy"},     64'(busy),     64'd0);
    check({pfx, "_done"},     64'(done),     64'd0);
    check({pfx, "_err"},      64'(err),      64'd0);
    check({pfx, "_err_code"}, 64'(err_code), 64'd0);
    check({pfx, "_in_ready"}, 64'(in_ready), 64'd1);
  endtask

  // Single-word frame: addr 0x010, word 35'h4_8000_0001, CHK 0x95.
  task automatic load_single(input logic [7:0] chk_byte);
    frm = {8'hA5, 8'h00, 8'h10, 8'h00, 8'h01, 8'h00, 8'h00, 8'h80, 8'h04, chk_byte};
  endtask

  task automatic check_single_good(input string pfx, input int gap_max);
    int d0;
    clear_log();
    d0 = done_cnt;
    load_single(8'h95);
    send_frame(gap_max);
    check({pfx, "_done"},     64'(done),     64'd1);
    check({pfx, "_cpu_hold"}, 64'(cpu_hold), 64'd0);
    check({pfx, "_err"},      64'(err),      64'd0);
    idle(2);
    check({pfx, "_done_cnt"}, 64'(done_cnt - d0), 64'd1);
    check({pfx, "_nwr"},      64'(wa_q.size()),   64'd1);
    if (wa_q.size() == 1) begin
      check({pfx, "_addr"},  64'(wa_q[0]), 64'h010);
      check({pfx, "_wdata"}, 64'(wd_q[0]), 64'h4_8000_0001);
    end
  endtask

  // Two words starting at 0xFFF: 35'h5_4433_2211 then 35'h2_DDCC_BBAA.
  // CHK = 0F^FF^01 ^ 11^22^33^44^05 ^ AA^BB^CC^DD^02 = B2.
  task automatic check_wrap(input string pfx, input int gap_max);
    int d0;
    clear_log();
    d0 = done_cnt;
    frm = {8'hA5, 8'h0F, 8'hFF, 8'h01,
           8'h11, 8'h22, 8'h33, 8'h44, 8'h05,
           8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h02,
           8'hB2};
    send_frame(gap_max);
    check({pfx, "_done"},     64'(done),     64'd1);
    check({pfx, "_cpu_hold"}, 64'(cpu_hold), 64'd0);
    idle(2);
    check({pfx, "_done_cnt"}, 64'(done_cnt - d0), 64'd1);
    check({pfx, "_nwr"},      64'(wa_q.size()),   64'd2);
    if (wa_q.size() == 2) begin
      check({pfx, "_addr0"},  64'(wa_q[0]), 64'hFFF);
      check({pfx, "_wdata0"}, 64'(wd_q[0]), 64'h5_4433_2211);
      check({pfx, "_addr1"},  64'(wa_q[1]), 64'h000);
      check({pfx, "_wdata1"}, 64'(wd_q[1]), 64'h2_DDCC_BBAA);
      if (gap_max == 0) check({pfx, "_spacing"}, 64'(wc_q[1] - wc_q[0]), 64'd6);
    end
  endtask

  initial begin
    int d0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (2) @(negedge clk);
    check_reset_vals("rst");
    rst_n = 1'b1;
    @(negedge clk);

    check_single_good("single", 0);
    check("single_done_pulse", 64'(done), 64'd0);

    check_wrap("wrap", 0);
    check("wrap_rdy_in_write", 64'(rdy_in_write), 64'd0);

    // Bad checksum: word still written, hold reasserted, no done.
    clear_log();
    d0 = done_cnt;
    load_single(8'h94);
    send_frame(0);
    check("badchk_err",      64'(err),      64'd1);
    check("badchk_code",     64'(err_code), 64'(ERR_CHK));
    check("badchk_cpu_hold", 64'(cpu_hold), 64'd1);
    idle(2);
    check("badchk_done_cnt", 64'(done_cnt - d0), 64'd0);
    check("badchk_nwr",      64'(wa_q.size()),   64'd1);
    check("badchk_err_held", 64'(err),      64'd1);

    // Bad address high byte; the SYNC first clears the previous error.
    clear_log();
    send_byte(8'hA5);
    check("badaddr_sync_clr", 64'(err),  64'd0);
    check("badaddr_busy",     64'(busy), 64'd1);
    send_byte(8'h10);
    in_valid = 1'b0;
    check("badaddr_err",  64'(err),      64'd1);
    check("badaddr_code", 64'(err_code), 64'(ERR_ADDR));
    check("badaddr_busy_after", 64'(busy), 64'd0);
    idle(2);
    check("badaddr_nwr", 64'(wa_q.size()), 64'd0);

    // Bad word top byte.
    clear_log();
    frm = {8'hA5, 8'h00, 8'h10, 8'h00, 8'h01, 8'h00, 8'h00, 8'h80, 8'h0C};
    send_frame(0);
    check("badword_err",  64'(err),      64'd1);
    check("badword_code", 64'(err_code), 64'(ERR_WORD));
    check("badword_busy", 64'(busy),     64'd0);
    idle(2);
    check("badword_nwr",  64'(wa_q.size()), 64'd0);

    // Leading garbage is discarded, then a good frame with gaps.
    send_byte(8'h00);
    send_byte(8'hFF);
    in_valid = 1'b0;
    check("garbage_busy", 64'(busy), 64'd0);
    check_single_good("garbage", 2);

    // Random gaps on the wrapping two-word frame.
    rdy_in_write = 0;
    check_wrap("gaps", 3);
    check("gaps_rdy_in_write", 64'(rdy_in_write), 64'd0);

    // Reset in the middle of DATA.
    frm = {8'hA5, 8'h00, 8'h10, 8'h00, 8'h01, 8'h00, 8'h00};
    send_frame(0);
    check("midrst_busy_before", 64'(busy), 64'd1);
    do_reset();
    check_reset_vals("midrst");
    rst_n = 1'b1;
    @(negedge clk);
    check_single_good("after_rst", 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
